jpeg_idct_transpose: RTL and testbench

Ping-pong transpose buffer between the row IDCT stage and the column IDCT stage. Collects the 64 row-transformed samples of one 8x8 block, arriving two per beat, into one of two register banks. Replays each completed block column-wise, four samples per beat, with a valid/accept handshake. The second bank absorbs the next block while the first drains, so the upstream row stage, which has no backpressure, never stalls.

---
 rtl/jpeg_idct_pkg.sv | 12 +
 rtl/jpeg_idct_tbuf_bank.sv | 35 +++
 rtl/jpeg_idct_transpose.sv | 146 ++++++++++++++
 tb/tb_jpeg_idct_transpose.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_idct_pkg.sv
// Shared constants and types for the IDCT row/column stages and the transpose buffer between them.
package jpeg_idct_pkg;

    localparam int BLOCK_WRITES = 32;
    localparam int COL_BEATS    = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/jpeg_idct_tbuf_bank.sv
// One 8x8 sample bank: two-sample row write port, combinational four-sample column read port.
module jpeg_idct_tbuf_bank
    import jpeg_idct_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk_i,
    input  logic                wr_en_i,
    input  logic [2:0]          wr_row_i,
    input  logic [2:0]          wr_col_i,
    input  logic [2*DATA_W-1:0] wr_data_i,
    input  logic [2:0]          rd_col_i,
    input  logic                rd_half_i,
    output logic [DATA_W-1:0]   rd_data0_o,
    output logic [DATA_W-1:0]   rd_data1_o,
    output logic [DATA_W-1:0]   rd_data2_o,
    output logic [DATA_W-1:0]   rd_data3_o
);

    logic [DATA_W-1:0] mem [8][8];

    // Sample storage is never reset; the owning full flag says when it is meaningful.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_row_i][{wr_col_i[2:1], 1'b0}] <= wr_data_i[DATA_W-1:0];
            mem[wr_row_i][{wr_col_i[2:1], 1'b1}] <= wr_data_i[2*DATA_W-1:DATA_W];
        end
    end

    assign rd_data0_o = mem[{rd_half_i, 2'd0}][rd_col_i];
    assign rd_data1_o = mem[{rd_half_i, 2'd1}][rd_col_i];
    assign rd_data2_o = mem[{rd_half_i, 2'd2}][rd_col_i];
    assign rd_data3_o = mem[{rd_half_i, 2'd3}][rd_col_i];

endmodule

// File: rtl/jpeg_idct_transpose.sv
// Ping-pong transpose buffer: row-order writes into one bank while the other bank drains column-wise.
module jpeg_idct_transpose
    import jpeg_idct_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                img_start_i,
    input  logic                img_end_i,
    input  logic                inport_valid_i,
    input  logic [2*DATA_W-1:0] inport_data_i,
    input  logic [5:0]          inport_idx_i,
    output logic                outport_valid_o,
    output logic [DATA_W-1:0]   outport_data0_o,
    output logic [DATA_W-1:0]   outport_data1_o,
    output logic [DATA_W-1:0]   outport_data2_o,
    output logic [DATA_W-1:0]   outport_data3_o,
    output logic [3:0]          outport_idx_o,
    input  logic                outport_accept_i,
    output logic                overflow_o
);

    logic [1:0]  full_q;
    logic        wr_bank_q;
    logic        rd_bank_q;
    logic [4:0]  wr_cnt_q;
    logic [3:0]  beat_q;
    rd_state_t   state_q;
    logic        overflow_q;

    logic              vld_p1;
    logic [DATA_W-1:0] data0_p1, data1_p1, data2_p1, data3_p1;

    // Write stage p0: accept row samples into the current write bank.
    logic wr_en_p0;
    logic wr_last_p0;
    logic [1:0] full_set, full_clr;

    assign wr_en_p0   = inport_valid_i && !full_q[wr_bank_q] && !img_start_i;
    assign wr_last_p0 = wr_en_p0 && (wr_cnt_q == 5'(BLOCK_WRITES - 1));
    assign full_set   = wr_last_p0 ? (2'b01 << wr_bank_q) : 2'b00;

    // Read side: pick the beat that will be presented after this edge.
    logic       beat_acc, last_acc, load;
    logic       nxt_bank;
    logic [3:0] nxt_beat;

    assign beat_acc = vld_p1 && outport_accept_i;
    assign last_acc = beat_acc && (beat_q == 4'(COL_BEATS - 1));
    assign full_clr = last_acc ? (2'b01 << rd_bank_q) : 2'b00;

    always_comb begin
        load     = 1'b0;
        nxt_bank = rd_bank_q;
        nxt_beat = 4'd0;
        if (state_q == IDLE) begin
            load = full_q[rd_bank_q];
        end else if (last_acc) begin
            nxt_bank = ~rd_bank_q;
            load     = full_q[~rd_bank_q];
        end else if (beat_acc) begin
            nxt_beat = beat_q + 4'd1;
            load     = 1'b1;
        end
    end

    logic [DATA_W-1:0] bank_rd [2][4];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        jpeg_idct_tbuf_bank #(.DATA_W(DATA_W)) u_bank (
            .clk_i      (clk_i),
            .wr_en_i    (wr_en_p0 && (wr_bank_q == 1'(gi))),
            .wr_row_i   (inport_idx_i[5:3]),
            .wr_col_i   (inport_idx_i[2:0]),
            .wr_data_i  (inport_data_i),
            .rd_col_i   (nxt_beat[3:1]),
            .rd_half_i  (nxt_beat[0]),
            .rd_data0_o (bank_rd[gi][0]),
            .rd_data1_o (bank_rd[gi][1]),
            .rd_data2_o (bank_rd[gi][2]),
            .rd_data3_o (bank_rd[gi][3])
        );
    end

    // Output stage p1: registered column beat, held until accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= 5'd0;
            beat_q     <= 4'd0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
            vld_p1     <= 1'b0;
            data0_p1   <= '0;
            data1_p1   <= '0;
            data2_p1   <= '0;
            data3_p1   <= '0;
        end else if (img_start_i) begin
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= 5'd0;
            beat_q     <= 4'd0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            full_q <= (full_q & ~full_clr) | full_set;
            if (inport_valid_i && full_q[wr_bank_q])
                overflow_q <= 1'b1;
            if (wr_last_p0)
                wr_bank_q <= ~wr_bank_q;
            if (img_end_i || wr_last_p0)
                wr_cnt_q <= 5'd0;
            else if (wr_en_p0)
                wr_cnt_q <= wr_cnt_q + 5'd1;
            if (last_acc)
                rd_bank_q <= ~rd_bank_q;

            if (load) begin
                state_q  <= STREAM;
                vld_p1   <= 1'b1;
                beat_q   <= nxt_beat;
                data0_p1 <= bank_rd[nxt_bank][0];
                data1_p1 <= bank_rd[nxt_bank][1];
                data2_p1 <= bank_rd[nxt_bank][2];
                data3_p1 <= bank_rd[nxt_bank][3];
            end else if (last_acc) begin
                state_q <= IDLE;
                vld_p1  <= 1'b0;
            end
        end
    end

    assign outport_valid_o = vld_p1;
    assign outport_data0_o = data0_p1;
    assign outport_data1_o = data1_p1;
    assign outport_data2_o = data2_p1;
    assign outport_data3_o = data3_p1;
    assign outport_idx_o   = beat_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_jpeg_idct_transpose.sv
// Directed bench for jpeg_idct_transpose with a beat scoreboard filled as blocks are written.
module tb_jpeg_idct_transpose;

    localparam int DATA_W = 16;

    logic        clk;
    logic        rst;
    logic        img_start;
    logic        img_end;
    logic        in_valid;
    logic [31:0] in_data;
    logic [5:0]  in_idx;
    logic        out_valid;
    logic [15:0] d0, d1, d2, d3;
    logic [3:0]  out_idx;
    logic        accept;
    logic        overflow;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] d3;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;

    jpeg_idct_transpose #(.DATA_W(DATA_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .img_start_i      (img_start),
        .img_end_i        (img_end),
        .inport_valid_i   (in_valid),
        .inport_data_i    (in_data),
        .inport_idx_i     (in_idx),
        .outport_valid_o  (out_valid),
        .outport_data0_o  (d0),
        .outport_data1_o  (d1),
        .outport_data2_o  (d2),
        .outport_data3_o  (d3),
        .outport_idx_o    (out_idx),
        .outport_accept_i (accept),
        .overflow_o       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] val(input int base, input int r, input int c);
        return 16'(base + 8 * r + c);
    endfunction

    task automatic push_block(input int base);
        beat_t e;
        int col, half;
        for (int b = 0; b < 16; b++) begin
            col   = b / 2;
            half  = b % 2;
            e.idx = 4'(b);
            e.d0  = val(base, 4 * half + 0, col);
            e.d1  = val(base, 4 * half + 1, col);
            e.d2  = val(base, 4 * half + 2, col);
            e.d3  = val(base, 4 * half + 3, col);
            sb.push_back(e);
        end
    endtask

    task automatic write_block(input int base, input bit rev, input int n);
        int wi, r, c;
        for (int w = 0; w < n; w++) begin
            wi       = rev ? 31 - w : w;
            r        = wi / 4;
            c        = (wi % 4) * 2;
            in_valid = 1'b1;
            in_idx   = {3'(r), 3'(c)};
            in_data  = {val(base, r, c + 1), val(base, r, c)};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s: observed %0d beats pending after %0d cycles, expected 0", tag, sb.size(), n);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t got, exp_b;
        if (!rst && out_valid && accept) begin
            got = {out_idx, d0, d1, d2, d3};
            beats_seen++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat: observed idx=%0d data=%0d,%0d,%0d,%0d, expected no beat",
                       out_idx, d0, d1, d2, d3);
            end
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                checks++;
                assert (got === exp_b) else begin
                    errors++;
                    $error("FAIL beat: observed idx=%0d data=%0d,%0d,%0d,%0d expected idx=%0d data=%0d,%0d,%0d,%0d",
                           got.idx, got.d0, got.d1, got.d2, got.d3,
                           exp_b.idx, exp_b.d0, exp_b.d1, exp_b.d2, exp_b.d3);
                end
            end
        end
    end

    initial begin
        int seen0;
        int n;
        rst       = 1'b1;
        img_start = 1'b0;
        img_end   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_idx    = '0;
        accept    = 1'b0;

        #2;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_idx", 64'(out_idx), 64'd0);
        check("reset_data", {d0, d1, d2, d3}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single block, accept high, valid two cycles after the last write
        accept = 1'b1;
        push_block(0);
        write_block(0, 1'b0, 32);
        check("t1_valid_at_last_write", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("t1_valid_next_cycle", 64'(out_valid), 64'd1);
        check("t1_first_idx", 64'(out_idx), 64'd0);
        drain("t1_drain", 40);
        idle(3);
        check("t1_idle_after", 64'(out_valid), 64'd0);

        // Two stored blocks drain back-to-back with no bubble
        accept = 1'b0;
        push_block(0);
        push_block(100);
        write_block(0, 1'b1, 32);
        write_block(100, 1'b0, 32);
        idle(2);
        accept = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("t2_contiguous_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        drain("t2_drain", 5);
        check("t2_idle_after", 64'(out_valid), 64'd0);

        // Third block dropped while both banks are full
        accept = 1'b0;
        seen0  = beats_seen;
        push_block(200);
        push_block(300);
        write_block(200, 1'b0, 32);
        write_block(300, 1'b0, 32);
        check("t3_no_overflow_yet", 64'(overflow), 64'd0);
        write_block(400, 1'b0, 32);
        check("t3_overflow", 64'(overflow), 64'd1);
        idle(5);
        accept = 1'b1;
        drain("t3_drain", 80);
        idle(5);
        check("t3_beat_count", 64'(beats_seen - seen0), 64'd32);
        check("t3_overflow_sticky", 64'(overflow), 64'd1);

        // Mid-stream img_start abandons the block and clears overflow
        push_block(500);
        write_block(500, 1'b0, 32);
        idle(4);
        accept    = 1'b0;
        img_start = 1'b1;
        @(posedge clk); #1;
        img_start = 1'b0;
        check("t4_valid_drop", 64'(out_valid), 64'd0);
        check("t4_overflow_clear", 64'(overflow), 64'd0);
        sb.delete();
        accept = 1'b1;
        push_block(600);
        write_block(600, 1'b1, 32);
        drain("t4_drain", 40);
        idle(3);

        // Accept toggling: every beat held until taken
        accept = 1'b0;
        push_block(700);
        write_block(700, 1'b0, 32);
        @(posedge clk); #1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            accept = (i % 2 == 0);
            @(posedge clk); #1;
            n = i + 1;
            if (sb.size() == 0) break;
        end
        check("t5_toggle_cycles", 64'(n), 64'd31);
        accept = 1'b1;
        idle(3);
        check("t5_idle_after", 64'(out_valid), 64'd0);

        // Partial block discarded by img_end
        seen0 = beats_seen;
        write_block(800, 1'b0, 20);
        img_end = 1'b1;
        @(posedge clk); #1;
        img_end = 1'b0;
        push_block(900);
        write_block(900, 1'b1, 32);
        drain("t6_drain", 40);
        idle(5);
        check("t6_beat_count", 64'(beats_seen - seen0), 64'd16);

        // Asynchronous reset during beat 7
        push_block(1000);
        write_block(1000, 1'b0, 32);
        n = 0;
        while (!(out_valid && out_idx == 4'd7) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("t7_reached_beat7", 64'(out_idx), 64'd7);
        #2;
        rst = 1'b1;
        #1;
        check("t7_reset_valid", 64'(out_valid), 64'd0);
        check("t7_reset_idx", 64'(out_idx), 64'd0);
        check("t7_reset_data", {d0, d1, d2, d3}, 64'd0);
        check("t7_reset_overflow", 64'(overflow), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        push_block(1100);
        write_block(1100, 1'b0, 32);
        drain("t7_drain", 40);
        idle(3);
        check("t7_idle_after", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
